// File: rtl/nott_pkg.sv
// rtl/nott_pkg.sv - shared constants and helpers for the NOTT channel array
package nott_pkg;

  localparam int MODE_NOTT   = 0;
  localparam int MODE_DFF    = 1;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_LATENCY = 1;
  localparam int DEF_CNT_W   = 8;

  // Counts set bits of a channel vector of up to 32 channels
  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + 6'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/nott_cell.sv
// rtl/nott_cell.sv - one channel: IDLE/ARMED state, result bit, double-pulse detect
module nott_cell
  import nott_pkg::*;
#(
  parameter int MODE = MODE_NOTT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_in,
  input  logic i_evt,
  output logic o_result,
  output logic o_dbl
);

  logic r_armed;

  // A pulse coincident with the evaluation strobe belongs to the next window
  always_ff @(posedge clk) begin
    if (rst) begin
      r_armed <= 1'b0;
    end else if (i_evt) begin
      r_armed <= i_in;
    end else if (i_in) begin
      r_armed <= 1'b1;
    end
  end

  assign o_result = (MODE == MODE_DFF) ? r_armed : ~r_armed;
  assign o_dbl    = i_in & r_armed & ~i_evt;

endmodule

// File: rtl/nott_array.sv
// rtl/nott_array.sv - array of NOTT cells with output latency pipeline and double-pulse counter
module nott_array
  import nott_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LATENCY = DEF_LATENCY,
  parameter int MODE    = MODE_NOTT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             clk_evt,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             dbl_err,
  output logic [CNT_W-1:0] dbl_cnt
);

  localparam int SUM_W = CNT_W + 7;

  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] w_dbl;
  logic [5:0]       w_pop;
  logic [SUM_W-1:0] w_sum;
  logic [CNT_W-1:0] w_cnt_next;

  logic [WIDTH-1:0] r_data [LATENCY];
  logic [LATENCY-1:0] r_vld;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    nott_cell #(.MODE(MODE)) u_cell (
      .clk      (clk),
      .rst      (rst),
      .i_in     (in[g]),
      .i_evt    (clk_evt),
      .o_result (w_result[g]),
      .o_dbl    (w_dbl[g])
    );
  end

  assign w_pop = popcount32(32'(w_dbl));

  always_comb begin
    w_sum      = SUM_W'(r_cnt) + SUM_W'(w_pop);
    w_cnt_next = w_sum[CNT_W-1:0];
    if (w_sum > SUM_W'({CNT_W{1'b1}})) begin
      w_cnt_next = {CNT_W{1'b1}};
    end
  end

  // Data is zeroed outside strobe cycles so out is non-zero only with out_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_data[i] <= '0;
      end
      r_vld <= '0;
      r_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_vld[0]  <= clk_evt;
      r_data[0] <= clk_evt ? w_result : '0;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_data[i] <= r_data[i-1];
      end
      r_err <= r_err | (|w_dbl);
      r_cnt <= w_cnt_next;
    end
  end

  assign out       = r_data[LATENCY-1];
  assign out_valid = r_vld[LATENCY-1];
  assign dbl_err   = r_err;
  assign dbl_cnt   = r_cnt;

endmodule

// File: tb/tb_nott_array.sv
// tb/tb_nott_array.sv - directed self-checking bench for nott_array
module tb_nott_array;
  import nott_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // A: NOTT, 4 channels, latency 1, 2-bit counter
  logic       rst_a, evt_a, vld_a, err_a;
  logic [3:0] in_a, out_a;
  logic [1:0] cnt_a;
  // B: DFF, 4 channels, latency 2, 8-bit counter
  logic       rst_b, evt_b, vld_b, err_b;
  logic [3:0] in_b, out_b;
  logic [7:0] cnt_b;
  // C: NOTT, 4 channels, latency 3
  logic       rst_c, evt_c, vld_c, err_c;
  logic [3:0] in_c, out_c;
  logic [7:0] cnt_c;

  nott_array #(.WIDTH(4), .LATENCY(1), .MODE(MODE_NOTT), .CNT_W(2)) u_a (
    .clk(clk), .rst(rst_a), .in(in_a), .clk_evt(evt_a),
    .out(out_a), .out_valid(vld_a), .dbl_err(err_a), .dbl_cnt(cnt_a));

  nott_array #(.WIDTH(4), .LATENCY(2), .MODE(MODE_DFF), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst_b), .in(in_b), .clk_evt(evt_b),
    .out(out_b), .out_valid(vld_b), .dbl_err(err_b), .dbl_cnt(cnt_b));

  nott_array #(.WIDTH(4), .LATENCY(3), .MODE(MODE_NOTT), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst_c), .in(in_c), .clk_evt(evt_c),
    .out(out_c), .out_valid(vld_c), .dbl_err(err_c), .dbl_cnt(cnt_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  int seen;

  initial begin
    rst_a = 1; evt_a = 0; in_a = 0;
    rst_b = 1; evt_b = 0; in_b = 0;
    rst_c = 1; evt_c = 0; in_c = 0;
    tick(2);
    // inputs during reset must be ignored
    in_a = 4'hF; evt_a = 1;
    tick();
    rst_a = 0; rst_b = 0; rst_c = 0; in_a = 0; evt_a = 0;
    check("a_rst_vld", vld_a, 0);
    check("a_rst_out", out_a, 0);
    check("a_rst_err", err_a, 0);
    check("a_rst_cnt", cnt_a, 0);

    // A: pulse on ch0 at t0, evt at t3
    in_a = 4'b0001; tick();
    in_a = 0; tick(2);
    check("a_no_evt_vld", vld_a, 0);
    evt_a = 1; tick(); evt_a = 0;
    check("a_t4_vld", vld_a, 1);
    check("a_t4_out", out_a, 4'b1110);
    tick();
    check("a_t5_vld", vld_a, 0);
    check("a_t5_out", out_a, 0);
    evt_a = 1; tick(); evt_a = 0;
    check("a_t7_out", out_a, 4'hF);

    // A: pulse coincident with evt lands in the next window
    in_a = 4'b0010; evt_a = 1; tick(); in_a = 0; evt_a = 0;
    check("a_same_out", out_a, 4'hF);
    evt_a = 1; tick(); evt_a = 0;
    check("a_next_out", out_a, 4'b1101);

    // A: double pulse on ch2, then saturation at 3
    in_a = 4'b0100; tick(); tick(); in_a = 0;
    check("a_dbl_cnt1", cnt_a, 1);
    check("a_dbl_err", err_a, 1);
    evt_a = 1; tick(); evt_a = 0;
    check("a_dbl_out", out_a, 4'b1011);
    for (int w = 0; w < 4; w++) begin
      in_a = 4'b0100; tick(); tick(); in_a = 0;
      evt_a = 1; tick(); evt_a = 0;
    end
    check("a_dbl_sat", cnt_a, 3);
    check("a_err_sticky", err_a, 1);

    // B: DFF, latency 2
    check("b_rst_cnt", cnt_b, 0);
    in_b = 4'b0101; tick(); in_b = 0;
    evt_b = 1; tick(); evt_b = 0;
    check("b_lat_vld0", vld_b, 0);
    tick();
    check("b_out1_vld", vld_b, 1);
    check("b_out1", out_b, 4'b0101);
    evt_b = 1; tick(); evt_b = 0; tick();
    check("b_out2_vld", vld_b, 1);
    check("b_out2", out_b, 4'b0000);

    // B: three back-to-back evaluations
    in_b = 4'b0001; tick();
    in_b = 4'b0010; evt_b = 1; tick();
    check("b_bb_vld0", vld_b, 0);
    in_b = 4'b0100; tick();
    check("b_bb1_vld", vld_b, 1);
    check("b_bb1", out_b, 4'b0001);
    in_b = 0; tick(); evt_b = 0;
    check("b_bb2_vld", vld_b, 1);
    check("b_bb2", out_b, 4'b0010);
    tick();
    check("b_bb3_vld", vld_b, 1);
    check("b_bb3", out_b, 4'b0100);
    tick();
    check("b_bb_end", vld_b, 0);

    // B: simultaneous doubles on all channels count per channel
    in_b = 4'hF; tick(); tick();
    check("b_pop4", cnt_b, 4);
    tick(); in_b = 0;
    check("b_pop8", cnt_b, 8);
    check("b_err", err_b, 1);
    evt_b = 1; tick(); evt_b = 0; tick();
    check("b_pop_out", out_b, 4'hF);

    // C: in-flight result dropped by reset
    in_c = 4'b0011; tick(); in_c = 4'b0001; tick(); in_c = 0;
    check("c_cnt_pre", cnt_c, 1);
    evt_c = 1; tick(); evt_c = 0;
    rst_c = 1; tick(); rst_c = 0;
    check("c_rst_vld", vld_c, 0);
    check("c_rst_cnt", cnt_c, 0);
    check("c_rst_err", err_c, 0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (vld_c) seen++;
      tick();
    end
    check("c_dropped", seen, 0);
    evt_c = 1; tick(); evt_c = 0; tick();
    check("c_lat_vld", vld_c, 0);
    tick();
    check("c_post_vld", vld_c, 1);
    check("c_post_out", out_c, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nott_array.md
NOTT_ARRAY -- requirements
Module: nott_array

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of independent channels, 1..32.
REQ-002 SHALL have parameter LATENCY, default 1: cycles from clk_evt to output strobe, 1..4.
REQ-003 SHALL have parameter MODE, default MODE_NOTT: MODE_NOTT outputs inverted, MODE_DFF outputs non-inverted.
REQ-004 SHALL have parameter CNT_W, default 8: width of the double-pulse counter.
REQ-005 Clock and reset are decided: one clock; reset is synchronous and active-high.
REQ-006 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-007 Port rst  input  1  synchronous, active-high reset.
REQ-008 Port in  input  WIDTH  per-channel data pulses, one-cycle strobes.
REQ-009 Port clk_evt  input  1  evaluation strobe (modelled SFQ clock pulse), one cycle wide.
REQ-010 Port out  output  WIDTH  per-channel result, non-zero only in the out_valid cycle.
REQ-011 Port out_valid  output  1  one-cycle strobe marking an evaluation result.
REQ-012 Port dbl_err  output  1  sticky flag: some channel received a second pulse in one window.
REQ-013 Port dbl_cnt  output  CNT_W  saturating count of double-pulse events.

Function
REQ-014 Each channel SHALL hold a 1-bit state: IDLE (no pulse since last clk_evt) or ARMED (pulse seen).
REQ-015 A channel with in high and no clk_evt SHALL move IDLE->ARMED.
REQ-016 On clk_evt, each channel SHALL sample its state and return to IDLE.
REQ-017 The sampled result SHALL be ~ARMED in MODE_NOTT and ARMED in MODE_DFF.
REQ-018 out and out_valid SHALL assert exactly LATENCY cycles after the clk_evt cycle, for one cycle.
REQ-019 When in and clk_evt are high in the same cycle, the current window SHALL be evaluated first. The pulse SHALL then belong to the next window, so that channel ends ARMED.
REQ-020 Back-to-back clk_evt in consecutive cycles SHALL each produce their own result. The pipeline SHALL be fully pipelined with no stall.
REQ-021 A pulse on an already-ARMED channel SHALL leave it ARMED. It SHALL add 1 to dbl_cnt for each such channel in that cycle, saturating at 2^CNT_W-1.
REQ-022 dbl_err SHALL set on any double pulse and stay set until reset.
REQ-023 With no clk_evt, out and out_valid SHALL remain 0 regardless of in.

Reset
REQ-024 With rst high, all channels SHALL go to IDLE.
REQ-025 With rst high, the latency pipeline SHALL clear: out=0 and out_valid=0.
REQ-026 With rst high, dbl_err=0 and dbl_cnt=0.
REQ-027 in and clk_evt in a reset cycle SHALL be ignored.
REQ-028 Results in flight when rst asserts SHALL be dropped and never emitted.
REQ-029 Out of reset, the first clk_evt with no prior in SHALL give out all-ones in MODE_NOTT and all-zeros in MODE_DFF.

Structure
REQ-030 Package nott_pkg SHALL hold the MODE_NOTT/MODE_DFF constants.
REQ-031 Package nott_pkg SHALL hold the default WIDTH, LATENCY and CNT_W values.
REQ-032 Sub-module nott_cell SHALL implement one channel's IDLE/ARMED state, result bit and double-pulse detect. It SHALL be instantiated WIDTH times.
REQ-033 The top level SHALL hold the LATENCY-deep output pipeline, popcount of double pulses, and the saturating counter.

Verification
REQ-034 MODE_NOTT, WIDTH=1, LATENCY=1: in pulse at t0, clk_evt at t3 -> out=0, out_valid=1 at t4. clk_evt at t6 with no in -> out=1 at t7.
REQ-035 MODE_DFF, WIDTH=4: in=4'b0101 pulse, then clk_evt -> out=4'b0101. Second clk_evt with no in -> out=4'b0000.
REQ-036 in=1 and clk_evt in the same cycle, previously IDLE, MODE_NOTT -> that result=1. Next clk_evt -> result=0.
REQ-037 Two pulses on channel 2 in one window, CNT_W=2 -> dbl_cnt=1 and dbl_err=1. Four more such windows -> dbl_cnt stays at 3.
REQ-038 LATENCY=3: clk_evt at t0, rst at t1 -> no out_valid at t3. After reset, state is IDLE and dbl_cnt=0.
REQ-039 Back-to-back clk_evt on 3 consecutive cycles with LATENCY=2 -> 3 consecutive out_valid cycles with correct per-window data.
